// File: rtl/dmem_ctrl_param.sv
// Data-memory controller with configurable access latency, valid/ready handshake,
// RV32 byte/half/word sizing and misalignment detection.
module dmem_ctrl_param #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            req_ready,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            misaligned,
  output logic            stall
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = XLEN / 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  state_t          stateNext;
  logic [3:0]      cnt;
  logic [3:0]      cntNext;
  logic            weQ;
  logic [2:0]      f3Q;
  logic [AW+1:0]   addrQ;
  logic [XLEN-1:0] wdataQ;
  logic            misQ;
  logic [XLEN-1:0] rdataQ;
  logic            misIn;
  logic            accept;
  logic [1:0]      szIn;
  logic [AW-1:0]   idx;
  logic [XLEN-1:0] word;
  logic [XLEN-1:0] byteSel;
  logic [XLEN-1:0] halfSel;
  logic [XLEN-1:0] loadData;
  logic [XLEN-1:0] rspData;
  logic [NB-1:0]   wmask;
  logic [XLEN-1:0] wdat;
  logic            doWrite;
  logic            unusedAddr;

  logic [XLEN-1:0] mem [DEPTH];

  assign unusedAddr = ^req_addr[XLEN-1:AW+2];

  assign szIn   = req_funct3[1:0];
  assign misIn  = ((szIn == 2'b01) & req_addr[0]) |
                  (szIn[1] & (req_addr[1:0] != 2'b00));
  assign accept = (state == IDLE) & req_valid;

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          cntNext   = 4'(LATENCY - 1);
          stateNext = (LATENCY == 1 || misIn) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cntNext = cnt - 4'd1;
        if (cnt <= 4'd1) stateNext = RESP;
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      rdataQ <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (accept) begin
        weQ    <= req_we;
        f3Q    <= req_funct3;
        addrQ  <= req_addr[AW+1:0];
        wdataQ <= req_wdata;
        misQ   <= misIn;
      end
      if (state == RESP) rdataQ <= rspData;
    end
  end

  assign idx     = addrQ[AW+1:2];
  assign word    = mem[idx];
  assign byteSel = word >> {addrQ[1:0], 3'b000};
  assign halfSel = word >> {addrQ[1], 4'b0000};

  always_comb begin
    loadData = word;
    unique case (f3Q[1:0])
      2'b00: loadData = f3Q[2] ?
        {{(XLEN-8){1'b0}}, byteSel[7:0]} :
        {{(XLEN-8){byteSel[7]}}, byteSel[7:0]};
      2'b01: loadData = f3Q[2] ?
        {{(XLEN-16){1'b0}}, halfSel[15:0]} :
        {{(XLEN-16){halfSel[15]}}, halfSel[15:0]};
      default: loadData = word;
    endcase
  end

  assign rspData = misQ ? '0 : loadData;

  // Lane mask plus replicated data lets one loop serve every store size
  always_comb begin
    wmask = '0;
    wdat  = wdataQ;
    unique case (f3Q[1:0])
      2'b00: begin
        wmask[addrQ[1:0]] = 1'b1;
        wdat = {NB{wdataQ[7:0]}};
      end
      2'b01: begin
        wmask[{addrQ[1], 1'b0}] = 1'b1;
        wmask[{addrQ[1], 1'b1}] = 1'b1;
        wdat = {(NB/2){wdataQ[15:0]}};
      end
      default: begin
        wmask = '1;
        wdat  = wdataQ;
      end
    endcase
  end

  assign doWrite = (state == RESP) & weQ & ~misQ & ~reset;

  always_ff @(posedge clk) begin
    if (doWrite) begin
      for (int i = 0; i < NB; i++) begin
        if (wmask[i]) mem[idx][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  assign req_ready  = (state == IDLE);
  assign rsp_valid  = (state == RESP) & ~reset;
  assign misaligned = rsp_valid & misQ;
  assign rsp_rdata  = (state == RESP) ? rspData : rdataQ;
  assign stall      = req_valid & ~rsp_valid;

endmodule

// File: tb/tb_dmem_ctrl_param.sv
// Scoreboard bench for dmem_ctrl_param: a LATENCY=2 instance and
// a LATENCY=1 instance share request fields but have separate valids.
module tb_dmem_ctrl_param;

  localparam logic [2:0] FB  = 3'b000;
  localparam logic [2:0] FH  = 3'b001;
  localparam logic [2:0] FW  = 3'b010;
  localparam logic [2:0] FBU = 3'b100;

  logic        clk = 1'b0;
  logic        reset;
  logic        validA, validB, we;
  logic [2:0]  f3;
  logic [31:0] addr, wdata;
  logic        readyA, rspA, misA, stallA;
  logic        readyB, rspB, misB, stallB;
  logic [31:0] rdataA, rdataB;

  int nPass = 0;
  int nChk  = 0;
  int cyc   = 0;
  int lastRsp;
  int firstRsp;

  typedef struct {
    string       tag;
    logic [31:0] data;
    bit          isLoad;
    bit          mis;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dmem_ctrl_param #(.XLEN(32), .DEPTH(64), .LATENCY(2)) uDutA (
    .clk(clk), .reset(reset),
    .req_valid(validA), .req_we(we), .req_funct3(f3),
    .req_addr(addr), .req_wdata(wdata),
    .req_ready(readyA), .rsp_valid(rspA), .rsp_rdata(rdataA),
    .misaligned(misA), .stall(stallA)
  );

  dmem_ctrl_param #(.XLEN(32), .DEPTH(64), .LATENCY(1)) uDutB (
    .clk(clk), .reset(reset),
    .req_valid(validB), .req_we(we), .req_funct3(f3),
    .req_addr(addr), .req_wdata(wdata),
    .req_ready(readyB), .rsp_valid(rspB), .rsp_rdata(rdataB),
    .misaligned(misB), .stall(stallB)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nChk++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic doOp(input bit sel, input bit w, input logic [2:0] fn,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] e, input string tag);
    exp_t x, y;
    int n;
    logic [1:0] sz;
    @(negedge clk);
    we = w; f3 = fn; addr = a; wdata = d;
    if (sel) validB = 1'b1;
    else validA = 1'b1;
    sz = fn[1:0];
    x.tag    = tag;
    x.isLoad = !w;
    x.mis    = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
    x.data   = x.mis ? 32'h0 : e;
    x.lat    = x.mis ? 1 : (sel ? 1 : 2);
    sb.push_back(x);
    #1;
    check({tag, "/ready"}, sel ? readyB : readyA, 1);
    check({tag, "/stall0"}, sel ? stallB : stallA, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!(sel ? rspB : rspA))
        check({tag, "/stallW"}, sel ? stallB : stallA, 1);
    end while (!(sel ? rspB : rspA) && n < 20);
    y = sb.pop_front();
    check({y.tag, "/lat"}, n, y.lat);
    check({y.tag, "/mis"}, sel ? misB : misA, y.mis);
    if (y.isLoad || y.mis)
      check({y.tag, "/data"}, sel ? rdataB : rdataA, y.data);
    check({y.tag, "/stallR"}, sel ? stallB : stallA, 0);
    lastRsp = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; validA = 1'b0; validB = 1'b0;
    we = 1'b0; f3 = FW; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst/ready", readyA, 1);
    check("rst/rsp", rspA, 0);
    check("rst/mis", misA, 0);
    check("rst/rdata", rdataA, 0);

    doOp(0, 1, FW, 32'h10, 32'hDEADBEEF, 0, "sw10");
    doOp(0, 0, FW, 32'h10, 0, 32'hDEADBEEF, "lw10");
    validA = 1'b0;
    @(negedge clk);
    check("hold/rdata", rdataA, 32'hDEADBEEF);

    doOp(0, 1, FW, 32'h20, 32'h0, 0, "sw20");
    doOp(0, 1, FB, 32'h22, 32'hF0, 0, "sb22");
    doOp(0, 0, FW, 32'h20, 0, 32'h00F00000, "lw20");
    doOp(0, 0, FB, 32'h22, 0, 32'hFFFFFFF0, "lb22");
    doOp(0, 0, FBU, 32'h22, 0, 32'h000000F0, "lbu22");
    doOp(0, 0, FH, 32'h22, 0, 32'h000000F0, "lh22");
    doOp(0, 1, FW, 32'h24, 32'h0, 0, "sw24");
    doOp(0, 1, FH, 32'h26, 32'h00008001, 0, "sh26");
    doOp(0, 0, FH, 32'h26, 0, 32'hFFFF8001, "lh26");
    doOp(0, 0, 3'b101, 32'h26, 0, 32'h00008001, "lhu26");
    doOp(0, 0, FW, 32'h24, 0, 32'h80010000, "lw24");

    doOp(0, 1, FW, 32'h30, 32'h13572468, 0, "sw30");
    doOp(0, 1, FH, 32'h31, 32'h1234, 0, "sh31mis");
    doOp(0, 0, FW, 32'h30, 0, 32'h13572468, "lw30");
    doOp(0, 0, FW, 32'h32, 0, 0, "lw32mis");

    doOp(0, 1, FW, 32'h40, 32'h55555555, 0, "sw40");
    validA = 1'b0;
    @(negedge clk);
    we = 1'b1; f3 = FW; addr = 32'h40; wdata = 32'hAAAAAAAA;
    validA = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1; validA = 1'b0;
    @(negedge clk);
    check("abort/rsp", rspA, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort/ready", readyA, 1);
    check("abort/rsp2", rspA, 0);
    check("abort/rdata", rdataA, 0);
    doOp(0, 0, FW, 32'h40, 0, 32'h55555555, "lw40");

    doOp(0, 1, FW, 32'h100, 32'hCAFEF00D, 0, "sw100");
    doOp(0, 0, FW, 32'h000, 0, 32'hCAFEF00D, "lwWrap");
    validA = 1'b0;

    doOp(1, 1, FW, 32'h0, 32'h11111111, 0, "b2bSw");
    firstRsp = lastRsp;
    doOp(1, 0, FW, 32'h0, 0, 32'h11111111, "b2bLw");
    check("b2b/gap", lastRsp - firstRsp, 2);
    doOp(1, 1, FH, 32'h3, 32'h0, 0, "b2bMis");
    validB = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
